// File: rtl/count_dbg_pkg.sv
// rtl/count_dbg_pkg.sv - shared types and defaults for the counter debug checker
// Contents: checker state enum, default count width, default lock threshold,
// width of the internal consecutive-match counter.
package count_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  localparam int COUNT_W      = 4;
  localparam int LOCK_CNT_DEF = 4;
  localparam int RUN_W        = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating incrementer with priority clear
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   clr  clear to zero, wins over inc
//   inc  add one unless already all-ones
//   cnt  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - lock-then-check sequence monitor for a free-running up-counter
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    count_in carries a sample this cycle; low freezes the checker
//   count_in    sampled counter value
//   clr_errs    clear err_count, sticky_err and last_bad on the next edge
//   locked      high while the stream is tracked as in-sequence
//   err_pulse   one cycle per sequence break seen while locked
//   sticky_err  held high after any break until cleared
//   err_count   saturating break count
//   expected    value the next valid sample must carry
//   last_bad    count_in of the most recent break
module count_seq_checker
  import count_dbg_pkg::*;
#(
  parameter int WIDTH    = COUNT_W,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [WIDTH-1:0]                      count_in,
  input  logic                                  clr_errs,
  (* mark_debug = "true" *) output logic        locked,
  (* mark_debug = "true" *) output logic        err_pulse,
  output logic                                  sticky_err,
  (* mark_debug = "true" *) output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0]                      expected,
  output logic [WIDTH-1:0]                      last_bad
);

  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);

  state_t           state;
  state_t           state_nx;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic [WIDTH-1:0] next_exp;
  logic             match;
  logic             brk;

  assign match    = (count_in == expected);
  assign run_inc  = run + RUN_W'(1);
  // Natural wrap of the WIDTH-bit add makes max -> 0 a match.
  assign next_exp = count_in + WIDTH'(1);
  // Breaks only count while locked; unlocked mismatches just reseed.
  assign brk      = in_valid && (state == ST_LOCKED) && !match;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (in_valid) begin
      case (state)
        ST_IDLE:    state_nx = ST_ACQUIRE;
        ST_ACQUIRE: if (match && (run_inc == LOCK_V)) state_nx = ST_LOCKED;
        ST_LOCKED:  if (!match) state_nx = ST_ACQUIRE;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  // Output logic: locked is decoded from the state register only.
  always_comb begin
    locked = (state == ST_LOCKED);
  end

  // Tracking datapath and error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      expected   <= '0;
      run        <= '0;
      err_pulse  <= 1'b0;
      sticky_err <= 1'b0;
      last_bad   <= '0;
    end else begin
      err_pulse <= brk;

      if (in_valid) begin
        expected <= next_exp;
        if ((state == ST_ACQUIRE) && match) begin
          run <= run_inc;
        end else if (state != ST_LOCKED || !match) begin
          run <= '0;
        end
      end

      // Clear wins over a same-cycle break; err_pulse above is unaffected.
      if (clr_errs) begin
        sticky_err <= 1'b0;
        last_bad   <= '0;
      end else if (brk) begin
        sticky_err <= 1'b1;
        last_bad   <= count_in;
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr_errs),
    .inc(brk),
    .cnt(err_count)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - self-checking bench for count_seq_checker
module tb_count_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  count_in = 4'd0;
  logic        clr_errs = 1'b0;

  logic        locked, err_pulse, sticky_err;
  logic [15:0] err_count;
  logic [3:0]  expected, last_bad;

  logic        s_locked, s_err_pulse, s_sticky_err;
  logic [1:0]  s_err_count;
  logic [3:0]  s_expected, s_last_bad;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state, expressed as stream properties
  bit seen_any;
  bit m_locked;
  int m_streak;
  int m_exp;
  int m_errs;
  bit m_sticky;
  int m_last_bad;
  bit m_pulse;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
    .clr_errs(clr_errs), .locked(locked), .err_pulse(err_pulse),
    .sticky_err(sticky_err), .err_count(err_count), .expected(expected),
    .last_bad(last_bad)
  );

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
    .clr_errs(clr_errs), .locked(s_locked), .err_pulse(s_err_pulse),
    .sticky_err(s_sticky_err), .err_count(s_err_count), .expected(s_expected),
    .last_bad(s_last_bad)
  );

  task automatic model_update(input bit r, input bit v, input int c, input bit cl);
    bit broke;
    broke = 0;
    if (r) begin
      seen_any = 0; m_locked = 0; m_streak = 0; m_exp = 0;
      m_errs = 0; m_sticky = 0; m_last_bad = 0; m_pulse = 0;
      return;
    end
    if (v) begin
      if (!seen_any) begin
        seen_any = 1;
        m_streak = 0;
      end else if (c == m_exp) begin
        if (!m_locked) begin
          m_streak++;
          if (m_streak == 4) m_locked = 1;
        end
      end else begin
        if (m_locked) broke = 1;
        m_locked = 0;
        m_streak = 0;
      end
      m_exp = (c + 1) % 16;
    end
    if (cl) begin
      m_errs = 0; m_sticky = 0; m_last_bad = 0;
    end else if (broke) begin
      m_errs++; m_sticky = 1; m_last_bad = c;
    end
    m_pulse = broke;
  endtask

  task automatic step(input bit r, input bit v, input int c, input bit cl);
    rst = r; in_valid = v; count_in = 4'(c); clr_errs = cl;
    @(posedge clk);
    model_update(r, v, c % 16, cl);
    #1;
  endtask

  task automatic send_run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, m_exp, 0);
  endtask

  task automatic break_and_relock();
    int bad;
    bad = (m_exp + 5) % 16;
    step(0, 1, bad, 0);
    send_run(4);
  endtask

  task automatic test_reset();
    step(1, 1, 10, 1);
    n_total++;
    if ({locked, err_pulse, sticky_err, err_count, expected, last_bad} !== 27'd0)
      $display("FAIL reset_main got l=%0b p=%0b s=%0b e=%0d x=%0d b=%0d want all 0",
               locked, err_pulse, sticky_err, err_count, expected, last_bad);
    else n_pass++;
    n_total++;
    if ({s_locked, s_err_pulse, s_sticky_err, s_err_count, s_expected, s_last_bad} !== 13'd0)
      $display("FAIL reset_sat got l=%0b p=%0b s=%0b e=%0d x=%0d b=%0d want all 0",
               s_locked, s_err_pulse, s_sticky_err, s_err_count, s_expected, s_last_bad);
    else n_pass++;
  endtask

  task automatic test_lock_up();
    for (int v = 3; v <= 7; v++) begin
      step(0, 1, v, 0);
      n_total++;
      if (locked !== (v == 7))
        $display("FAIL lock_up_locked sample=%0d got=%0b want=%0b", v, locked, (v == 7));
      else n_pass++;
    end
    n_total++;
    if (expected !== 4'd8) $display("FAIL lock_up_expected got=%0d want=8", expected);
    else n_pass++;
    n_total++;
    if (err_count !== 16'd0) $display("FAIL lock_up_errs got=%0d want=0", err_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int v = 8; v <= 13; v++) step(0, 1, v, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, (14 + i) % 16, 0);
      n_total++;
      if ({locked, err_pulse} !== 2'b10)
        $display("FAIL wrap_flags sample=%0d got l=%0b p=%0b want l=1 p=0",
                 (14 + i) % 16, locked, err_pulse);
      else n_pass++;
    end
    n_total++;
    if (expected !== 4'd2) $display("FAIL wrap_expected got=%0d want=2", expected);
    else n_pass++;
  endtask

  task automatic test_break();
    step(0, 1, 2, 0); step(0, 1, 3, 0); step(0, 1, 4, 0);
    step(0, 1, 9, 0);
    n_total++;
    if ({err_pulse, sticky_err, locked} !== 3'b110)
      $display("FAIL break_flags got p=%0b s=%0b l=%0b want p=1 s=1 l=0",
               err_pulse, sticky_err, locked);
    else n_pass++;
    n_total++;
    if (err_count !== 16'd1) $display("FAIL break_errs got=%0d want=1", err_count);
    else n_pass++;
    n_total++;
    if (last_bad !== 4'd9) $display("FAIL break_last_bad got=%0d want=9", last_bad);
    else n_pass++;
    n_total++;
    if (expected !== 4'd10) $display("FAIL break_expected got=%0d want=10", expected);
    else n_pass++;
    for (int v = 10; v <= 13; v++) begin
      step(0, 1, v, 0);
      n_total++;
      if (err_pulse !== 1'b0) $display("FAIL break_pulse_len sample=%0d got=%0b want=0", v, err_pulse);
      else n_pass++;
    end
    n_total++;
    if (locked !== 1'b1) $display("FAIL break_relock got=%0b want=1", locked);
    else n_pass++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, $urandom_range(0, 15), 0);
      n_total++;
      if ({expected, locked, err_pulse} !== {4'd14, 1'b1, 1'b0})
        $display("FAIL stall_hold cyc=%0d got x=%0d l=%0b p=%0b want x=14 l=1 p=0",
                 i, expected, locked, err_pulse);
      else n_pass++;
    end
    step(0, 1, 14, 0);
    n_total++;
    if ({err_pulse, locked, err_count, expected} !== {1'b0, 1'b1, 16'd1, 4'd15})
      $display("FAIL stall_resume got p=%0b l=%0b e=%0d x=%0d want p=0 l=1 e=1 x=15",
               err_pulse, locked, err_count, expected);
    else n_pass++;
  endtask

  task automatic test_clear_collision();
    int bad;
    break_and_relock();
    break_and_relock();
    n_total++;
    if (err_count !== 16'd3) $display("FAIL collide_pre_errs got=%0d want=3", err_count);
    else n_pass++;
    bad = (m_exp + 7) % 16;
    step(0, 1, bad, 1);
    n_total++;
    if ({err_pulse, locked, sticky_err} !== 3'b100)
      $display("FAIL collide_flags got p=%0b l=%0b s=%0b want p=1 l=0 s=0",
               err_pulse, locked, sticky_err);
    else n_pass++;
    n_total++;
    if ({err_count, last_bad} !== 20'd0)
      $display("FAIL collide_cleared got e=%0d b=%0d want e=0 b=0", err_count, last_bad);
    else n_pass++;
    n_total++;
    if (expected !== 4'((bad + 1) % 16))
      $display("FAIL collide_expected got=%0d want=%0d", expected, (bad + 1) % 16);
    else n_pass++;
  endtask

  task automatic test_saturation_and_reset();
    send_run(4);
    for (int i = 0; i < 5; i++) break_and_relock();
    n_total++;
    if (s_err_count !== 2'd3) $display("FAIL sat_errs got=%0d want=3", s_err_count);
    else n_pass++;
    n_total++;
    if (err_count !== 16'd5) $display("FAIL sat_wide_errs got=%0d want=5", err_count);
    else n_pass++;
    n_total++;
    if (locked !== 1'b1) $display("FAIL sat_locked got=%0b want=1", locked);
    else n_pass++;
    step(1, 1, m_exp + 3, 1);
    n_total++;
    if ({locked, err_pulse, sticky_err, err_count, expected, last_bad} !== 27'd0)
      $display("FAIL midrst_main got l=%0b p=%0b s=%0b e=%0d x=%0d b=%0d want all 0",
               locked, err_pulse, sticky_err, err_count, expected, last_bad);
    else n_pass++;
    n_total++;
    if ({s_locked, s_sticky_err, s_err_count} !== 4'd0)
      $display("FAIL midrst_sat got l=%0b s=%0b e=%0d want all 0",
               s_locked, s_sticky_err, s_err_count);
    else n_pass++;
  endtask

  task automatic test_random();
    int c, w16, w2;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : m_exp;
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, c,
           $urandom_range(0, 19) == 0);
      w16 = (m_errs > 65535) ? 65535 : m_errs;
      w2  = (m_errs > 3) ? 3 : m_errs;
      n_total++;
      if ({locked, err_pulse, sticky_err, err_count, expected, last_bad} !==
          {m_locked, m_pulse, m_sticky, 16'(w16), 4'(m_exp), 4'(m_last_bad)})
        $display("FAIL rnd_main cyc=%0d got l=%0b p=%0b s=%0b e=%0d x=%0d b=%0d want l=%0b p=%0b s=%0b e=%0d x=%0d b=%0d",
                 i, locked, err_pulse, sticky_err, err_count, expected, last_bad,
                 m_locked, m_pulse, m_sticky, w16, m_exp, m_last_bad);
      else n_pass++;
      n_total++;
      if (s_err_count !== 2'(w2))
        $display("FAIL rnd_sat cyc=%0d got=%0d want=%0d", i, s_err_count, w2);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_wrap();
    test_break();
    test_stall();
    test_clear_collision();
    test_saturation_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
